// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   localparam int unsigned PIPE_CNT_W_DEFAULT  = 32;
   localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      MEM_WAIT    = 2'd1,
      MULDIV_WAIT = 2'd2
   } pipe_state_t;

endpackage

// File: rtl/pipe_event_counter.sv
// Enable-driven wrapping event counter with synchronous active-high reset.
module pipe_event_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Performance counters are built only when PIPE_PERF_COUNTERS_EN is defined.
module pipeline_stall_sequencer
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
   parameter int unsigned CNT_W       = PIPE_CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_use,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             muldiv_req,
   input  logic             muldiv_done,
   output logic             muldiv_go,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             ex_mem_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_bubble,
   output logic             mem_wb_bubble,
   output logic             mem_timeout_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

   pipe_state_t       state;
   pipe_state_t       next_state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              done_latched;
   logic              done_set;
   logic              done_clr;
   logic              timeout_hit;
   logic              mem_freeze;

   assign mem_freeze = dmem_req && !dmem_ready;

   // State register, memory wait counter, latched muldiv_done and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= RUN;
         wait_cnt        <= '0;
         done_latched    <= 1'b0;
         mem_timeout_err <= 1'b0;
      end else begin
         state <= next_state;
         if (state != MEM_WAIT) begin
            wait_cnt <= '0;
         end else if (!dmem_ready) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
         if (done_set) begin
            done_latched <= 1'b1;
         end else if (done_clr) begin
            done_latched <= 1'b0;
         end
         if (timeout_hit) begin
            mem_timeout_err <= 1'b1;
         end
      end
   end

   // Next-state and combinational stage controls
   always_comb begin
      next_state    = state;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      ex_mem_write  = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
      mem_wb_bubble = 1'b0;
      muldiv_go     = 1'b0;
      done_set      = 1'b0;
      done_clr      = 1'b0;
      timeout_hit   = 1'b0;

      if (rst) begin
         next_state    = RUN;
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         ex_mem_write  = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
         ex_mem_bubble = 1'b1;
         mem_wb_bubble = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (mem_freeze) begin
                  pc_write      = 1'b0;
                  if_id_write   = 1'b0;
                  id_ex_write   = 1'b0;
                  ex_mem_write  = 1'b0;
                  mem_wb_bubble = 1'b1;
                  next_state    = MEM_WAIT;
               end else if (muldiv_req) begin
                  pc_write      = 1'b0;
                  if_id_write   = 1'b0;
                  id_ex_write   = 1'b0;
                  ex_mem_bubble = 1'b1;
                  muldiv_go     = 1'b1;
                  next_state    = MULDIV_WAIT;
               end else if (branch_taken) begin
                  // Branch squashes any load-use victim sitting behind it
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end

            MEM_WAIT: begin
               // On release the frozen registers replay branch/load-use next cycle
               if (dmem_ready) begin
                  next_state = RUN;
               end else begin
                  pc_write      = 1'b0;
                  if_id_write   = 1'b0;
                  id_ex_write   = 1'b0;
                  ex_mem_write  = 1'b0;
                  mem_wb_bubble = 1'b1;
                  if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                     timeout_hit = 1'b1;
                     next_state  = RUN;
                  end
               end
            end

            MULDIV_WAIT: begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               if (mem_freeze) begin
                  id_ex_write   = 1'b0;
                  ex_mem_write  = 1'b0;
                  mem_wb_bubble = 1'b1;
                  done_set      = muldiv_done;
               end else if (muldiv_done || done_latched) begin
                  done_clr   = 1'b1;
                  next_state = RUN;
               end else begin
                  id_ex_write   = 1'b0;
                  ex_mem_bubble = 1'b1;
               end
            end

            default: begin
               next_state = RUN;
            end
         endcase
      end
   end

   // A MUL/DIV in EX can never be younger than a taken branch in EX
   muldiv_with_branch_illegal: assert property (
      @(posedge clk) disable iff (rst) !(state == RUN && muldiv_req && branch_taken)
   );

`ifdef PIPE_PERF_COUNTERS_EN
   pipe_event_counter #(.CNT_W(CNT_W)) u_stall_counter (
      .clk   (clk),
      .rst   (rst),
      .en    (!pc_write),
      .count (stall_cycles)
   );

   pipe_event_counter #(.CNT_W(CNT_W)) u_flush_counter (
      .clk   (clk),
      .rst   (rst),
      .en    (if_id_flush),
      .count (flush_count)
   );
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Scoreboard bench: per-cycle expected controls from a behavioural model, checked by a monitor.
module tb_pipeline_stall_sequencer;

   localparam int unsigned MEM_TIMEOUT = 255;
   localparam int unsigned CNT_W       = 32;

   // Control word order: pc, if_id, id_ex, ex_mem writes | if_id_flush, id_ex_flush,
   // ex_mem_bubble, mem_wb_bubble | muldiv_go
   localparam logic [8:0] C_RUN      = 9'b1111_0000_0;
   localparam logic [8:0] C_RST      = 9'b0000_1111_0;
   localparam logic [8:0] C_MEMF     = 9'b0000_0001_0;
   localparam logic [8:0] C_MUL_GO   = 9'b0001_0010_1;
   localparam logic [8:0] C_MUL_HOLD = 9'b0001_0010_0;
   localparam logic [8:0] C_MUL_DONE = 9'b0011_0000_0;
   localparam logic [8:0] C_BRANCH   = 9'b1111_1100_0;
   localparam logic [8:0] C_LOADUSE  = 9'b0011_0100_0;

   localparam int M_RUN = 0;
   localparam int M_MEM = 1;
   localparam int M_MUL = 2;

   typedef struct packed {
      logic [8:0]       ctrl;
      logic             err;
      logic [CNT_W-1:0] stall;
      logic [CNT_W-1:0] flush;
      logic [31:0]      cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic load_use = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
   logic muldiv_req = 1'b0, muldiv_done = 1'b0;
   logic muldiv_go, pc_write, if_id_write, id_ex_write, ex_mem_write;
   logic if_id_flush, id_ex_flush, ex_mem_bubble, mem_wb_bubble, mem_timeout_err;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   pipeline_stall_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .load_use        (load_use),
      .branch_taken    (branch_taken),
      .dmem_req        (dmem_req),
      .dmem_ready      (dmem_ready),
      .muldiv_req      (muldiv_req),
      .muldiv_done     (muldiv_done),
      .muldiv_go       (muldiv_go),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .id_ex_write     (id_ex_write),
      .ex_mem_write    (ex_mem_write),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .ex_mem_bubble   (ex_mem_bubble),
      .mem_wb_bubble   (mem_wb_bubble),
      .mem_timeout_err (mem_timeout_err),
      .stall_cycles    (stall_cycles),
      .flush_count     (flush_count)
   );

   always #5 clk = ~clk;

   exp_t   sb[$];
   int     checks = 0;
   int     errors = 0;
   int     cyc    = 0;

   // Behavioural model: where the pipeline is and what it has accumulated so far
   int     m_mode    = M_RUN;
   int     m_waited  = 0;
   bit     m_pending = 1'b0;
   bit     m_err     = 1'b0;
   longint m_stall   = 0;
   longint m_flush   = 0;
   bit     last_go   = 1'b0;
   bit     mq_pending = 1'b0;

   task automatic step(input bit r, lu, bt, dq, dr, mq, md);
      exp_t       e;
      logic [8:0] c;
      int         nxt;
      @(posedge clk);
      #1;
      rst = r; load_use = lu; branch_taken = bt; dmem_req = dq;
      dmem_ready = dr; muldiv_req = mq; muldiv_done = md;
      cyc++;
      e.cyc = 32'(cyc);
      e.err = m_err;
`ifdef PIPE_PERF_COUNTERS_EN
      e.stall = CNT_W'(m_stall);
      e.flush = CNT_W'(m_flush);
`else
      e.stall = '0;
      e.flush = '0;
`endif
      nxt = m_mode;
      c   = C_RUN;
      if (r) begin
         c = C_RST;
      end else if (m_mode == M_RUN) begin
         if (dq && !dr) begin
            c = C_MEMF; nxt = M_MEM; m_waited = 0;
         end else if (mq) begin
            c = C_MUL_GO; nxt = M_MUL; m_pending = 1'b0;
         end else if (bt) begin
            c = C_BRANCH;
         end else if (lu) begin
            c = C_LOADUSE;
         end
      end else if (m_mode == M_MEM) begin
         if (dr) begin
            nxt = M_RUN;
         end else begin
            c = C_MEMF;
            m_waited++;
            if (m_waited == MEM_TIMEOUT) begin
               m_err = 1'b1; nxt = M_RUN;
            end
         end
      end else begin
         if (dq && !dr) begin
            c = C_MEMF;
            if (md) m_pending = 1'b1;
         end else if (md || m_pending) begin
            c = C_MUL_DONE; nxt = M_RUN; m_pending = 1'b0;
         end else begin
            c = C_MUL_HOLD;
         end
      end
      e.ctrl = c;
      sb.push_back(e);
      if (r) begin
         m_mode = M_RUN; m_waited = 0; m_pending = 1'b0; m_err = 1'b0;
         m_stall = 0; m_flush = 0;
      end else begin
         if (!c[8]) m_stall++;
         if (c[4])  m_flush++;
         m_mode = nxt;
      end
      last_go = c[0];
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: outputs are combinational, so compare mid-cycle on the falling edge
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [8:0] got;
         e   = sb.pop_front();
         got = {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush,
                id_ex_flush, ex_mem_bubble, mem_wb_bubble, muldiv_go};
         checks++;
         if (got !== e.ctrl) begin
            errors++;
            $display("FAIL ctrl cyc=%0d got=%b want=%b", e.cyc, got, e.ctrl);
         end
         checks++;
         if (mem_timeout_err !== e.err) begin
            errors++;
            $display("FAIL timeout_err cyc=%0d got=%b want=%b", e.cyc, mem_timeout_err, e.err);
         end
         checks++;
         if (stall_cycles !== e.stall || flush_count !== e.flush) begin
            errors++;
            $display("FAIL counters cyc=%0d got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     e.cyc, stall_cycles, flush_count, e.stall, e.flush);
         end
      end
   end

   initial begin
      @(posedge clk);
      // Reset held, then release with no requests
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      idle(2);
      // Single load-use
      step(0, 1, 0, 0, 0, 0, 0);
      idle(2);
      // Memory wait of three cycles, then ready
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0, 0);
      idle(2);
      // MUL/DIV with done on the fifth cycle
      step(0, 0, 0, 0, 0, 1, 0);
      idle(3);
      step(0, 0, 0, 0, 0, 0, 1);
      idle(2);
      // Branch and load-use together
      step(0, 1, 1, 0, 0, 0, 0);
      idle(2);
      // MUL/DIV done arriving during a memory freeze is honoured afterwards
      step(0, 0, 0, 0, 0, 1, 0);
      idle(1);
      step(0, 0, 0, 1, 0, 0, 1);
      step(0, 0, 0, 1, 0, 0, 0);
      idle(2);
      // Memory timeout and sticky error
      for (int i = 0; i < MEM_TIMEOUT + 3; i++) step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 1, 0, 0);
      idle(3);
      step(1, 0, 0, 0, 0, 0, 0);
      idle(2);
      // Reset mid-wait clears a latched done
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      idle(2);
      step(0, 0, 0, 0, 0, 0, 1);
      idle(2);
      // Randomized traffic obeying the request protocol
      mq_pending = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         bit r, lu, bt, dq, dr, mq, md;
         r  = ($urandom_range(0, 249) == 0);
         if (!mq_pending && m_mode == M_RUN && $urandom_range(0, 7) == 0) mq_pending = 1'b1;
         mq = mq_pending;
         bt = !mq && ($urandom_range(0, 5) == 0);
         lu = ($urandom_range(0, 4) == 0);
         dq = ($urandom_range(0, 3) == 0);
         dr = ($urandom_range(0, 2) != 0);
         md = (m_mode == M_MUL) && ($urandom_range(0, 3) == 0);
         step(r, lu, bt, dq, dr, mq, md);
         if (last_go || r) mq_pending = 1'b0;
      end
      idle(2);
      @(posedge clk);
      @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d entries want=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
